// File: rtl/hb_interp2.sv
// hb_interp2 - half-band 2x interpolator.
//
// Each accepted input sample produces two output samples. Phase 0 passes the
// centre-tap sample (x[k-2]) straight through. Phase 1 is the interpolated
// point from the half-band kernel [-1 0 9 16 9 0 -1]/16. The kernel is
// evaluated at the accept edge and parked in a hold register until phase 1
// is presented.
//
// Ports
//   i_clk    : clock
//   i_reset  : asynchronous reset, active-high
//   i_valid  : input sample valid
//   o_ready  : block can accept an input this cycle (never depends on i_valid)
//   i_data   : input sample, signed WIDTH bits
//   o_valid  : output sample valid (registered)
//   i_ready  : downstream accepts the output this cycle
//   o_data   : output sample, signed WIDTH bits (registered)
//   o_phase  : 0 = pass-through sample, 1 = interpolated sample (registered)
module hb_interp2 #(
    parameter int WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [WIDTH-1:0] i_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o_data,
    output logic                    o_phase
);

    // 9*(2*max) + 2*max + 8 fits comfortably in WIDTH+6 signed bits.
    localparam int ACC_W = WIDTH + 6;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OUT0 = 2'd1,
        OUT1 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] d0_q, d1_q, d2_q, d3_q;
    logic signed [WIDTH-1:0] hold_q, hold_d;
    logic                    o_valid_q, o_valid_d;
    logic                    o_phase_q, o_phase_d;
    logic signed [WIDTH-1:0] o_data_q, o_data_d;
    logic                    accept;

    // Add half an LSB of the output scale, then arithmetic shift: rounds
    // half toward +inf.
    function automatic logic signed [ACC_W-1:0] round_div16(
        input logic signed [ACC_W-1:0] v
    );
        return (v + ACC_W'(8)) >>> 4;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] c;
        if (v > SAT_MAX)      c = SAT_MAX;
        else if (v < SAT_MIN) c = SAT_MIN;
        else                  c = v;
        return c[WIDTH-1:0];
    endfunction

    // Kernel on the post-shift delay line: new d0 = i_data, new d1 = d0_q,
    // new d2 = d1_q, new d3 = d2_q.
    logic signed [ACC_W-1:0] e_in, e0, e1, e2;
    logic signed [ACC_W-1:0] s_ctr, s_out, acc;
    logic signed [WIDTH-1:0] p1;

    always_comb begin
        e_in  = ACC_W'(i_data);
        e0    = ACC_W'(d0_q);
        e1    = ACC_W'(d1_q);
        e2    = ACC_W'(d2_q);
        s_ctr = e0 + e1;
        s_out = e_in + e2;
        acc   = (s_ctr <<< 3) + s_ctr - s_out;
        p1    = sat(round_div16(acc));
    end

    assign o_ready = (state_q == IDLE) || ((state_q == OUT1) && i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        o_valid_d = o_valid_q;
        o_phase_d = o_phase_q;
        o_data_d  = o_data_q;

        case (state_q)
            IDLE: begin
                if (i_valid) state_d = OUT0;
            end
            OUT0: begin
                if (i_ready) state_d = OUT1;
            end
            OUT1: begin
                if (i_ready) state_d = i_valid ? OUT0 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            // Phase 0 is the sample that lands in d2 on this edge (old d1).
            o_data_d  = d1_q;
            o_phase_d = 1'b0;
            o_valid_d = 1'b1;
            hold_d    = p1;
        end else if ((state_q == OUT0) && (state_d == OUT1)) begin
            o_data_d  = hold_q;
            o_phase_d = 1'b1;
            o_valid_d = 1'b1;
        end else if (state_d == IDLE) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            hold_q    <= '0;
            o_valid_q <= 1'b0;
            o_phase_q <= 1'b0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            o_valid_q <= o_valid_d;
            o_phase_q <= o_phase_d;
            o_data_q  <= o_data_d;
            if (accept) begin
                d3_q <= d2_q;
                d2_q <= d1_q;
                d1_q <= d0_q;
                d0_q <= i_data;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_phase = o_phase_q;
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_hb_interp2.sv
module tb_hb_interp2;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic signed [7:0] i_data = '0;
    logic              o_valid;
    logic              i_ready = 1'b1;
    logic signed [7:0] o_data;
    logic              o_phase;

    hb_interp2 #(.WIDTH(8)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_phase(o_phase)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct {
        int data;
        int phase;
    } exp_t;

    exp_t exp_q[$];
    int   xs[$];      // every input accepted since the last reset
    int   obs[$];     // every output sample handed downstream
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   rdy_rand = 1'b0;
    bit   tp_watch = 1'b0;
    int   tp_gap = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int xat(input int j);
        int k;
        k = xs.size() - 1 - j;
        return (k >= 0) ? xs[k] : 0;
    endfunction

    function automatic int clamp8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_accept(input int v);
        exp_t e;
        int   num;
        real  y;
        xs.push_back(v);
        e.data  = xat(2);
        e.phase = 0;
        exp_q.push_back(e);
        num = 9 * (xat(1) + xat(2)) - xat(0) - xat(3);
        y   = $floor(real'(num) / 16.0 + 0.5);
        e.data  = clamp8(int'(y));
        e.phase = 1;
        exp_q.push_back(e);
    endtask

    // ---------------- background processes ----------------
    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial forever begin
        @(posedge i_clk);
        #1;
        if (rdy_rand) i_ready = ($urandom_range(0, 3) != 0);
    end

    initial forever begin
        @(negedge i_clk);
        if (tp_watch && !o_valid) tp_gap++;
    end

    // Monitor: an output handshake happens at the next rising edge.
    initial forever begin
        @(negedge i_clk);
        if (!i_reset && o_valid && i_ready) begin
            obs.push_back(int'(o_data));
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", int'(o_data), e.data);
                chk("out_phase", int'(o_phase), e.phase);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int v);
        bit got;
        got = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'(v);
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge i_clk);
            if (o_ready) got = 1'b1;
            @(posedge i_clk);
            if (got) model_accept(v);
        end
        #1;
        i_valid  = 1'b0;
        last_acc = cyc;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 300) begin
            @(posedge i_clk);
            c++;
        end
        repeat (3) @(posedge i_clk);
        #1;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #3 i_reset = 1'b1;
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        exp_q.delete();
        xs.delete();
        obs.delete();
    endtask

    task automatic chk_seq(input string nm, input int req[]);
        chk({nm, "_len"}, obs.size(), req.size());
        for (int i = 0; i < req.size() && i < obs.size(); i++)
            chk(nm, obs[i], req[i]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int imp[];
        int t0;
        int sd, sp;
        imp = '{0, -4, 0, 36, 64, 36, 0, -4, 0, 0};

        idle(3);
        #1 i_reset = 1'b0;
        idle(1);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_data", int'(o_data), 0);
        chk("rst_o_phase", int'(o_phase), 0);
        chk("rst_o_ready", int'(o_ready), 1);

        // Impulse response.
        i_ready = 1'b1;
        send(64); send(0); send(0); send(0); send(0);
        drain();
        chk_seq("impulse", imp);

        // Asynchronous reset while parked in the interpolated phase.
        do_reset();
        send(64);
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        #1;
        chk("pre_rst_phase", int'(o_phase), 1);
        #1 i_reset = 1'b1;
        #1;
        chk("async_rst_o_valid", int'(o_valid), 0);
        chk("async_rst_o_data", int'(o_data), 0);
        chk("async_rst_o_ready", int'(o_ready), 1);
        idle(2);
        i_ready = 1'b1;
        #1 i_reset = 1'b0;
        exp_q.delete();
        xs.delete();
        obs.delete();
        idle(1);

        // Throughput with i_valid held high.
        send(10);
        tp_watch = 1'b1;
        tp_gap   = 0;
        for (int i = 0; i < 8; i++) begin
            t0 = last_acc;
            send(i * 13 - 50);
            chk("tp_accept_gap", last_acc - t0, 2);
        end
        tp_watch = 1'b0;
        chk("tp_valid_gaps", tp_gap, 0);
        drain();

        // Saturation, both polarities.
        do_reset();
        send(127); send(-128); send(-128); send(127);
        drain();
        chk("sat_neg", obs[7], -128);
        do_reset();
        send(-128); send(127); send(127); send(-128);
        drain();
        chk("sat_pos", obs[7], 127);

        // Backpressure during phase 0 with a pending input.
        do_reset();
        send(64);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'sd0;
        @(negedge i_clk);
        sd = int'(o_data);
        sp = int'(o_phase);
        chk("bp_first_phase", sp, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge i_clk);
            chk("bp_data_stable", int'(o_data), sd);
            chk("bp_phase_stable", int'(o_phase), sp);
            chk("bp_o_ready", int'(o_ready), 0);
            chk("bp_o_valid", int'(o_valid), 1);
        end
        @(posedge i_clk);
        #1 i_ready = 1'b1;
        send(0); send(0); send(0); send(0);
        drain();
        chk_seq("bp_impulse", imp);

        // DC inputs.
        do_reset();
        for (int i = 0; i < 8; i++) send(127);
        drain();
        chk("dc_pos_p0", obs[14], 127);
        chk("dc_pos_p1", obs[15], 127);
        do_reset();
        for (int i = 0; i < 8; i++) send(-100);
        drain();
        chk("dc_neg_p0", obs[14], -100);
        chk("dc_neg_p1", obs[15], -100);

        // Random traffic with random downstream stalls.
        do_reset();
        rdy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int v;
            if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) != 0) ? 127 : -128;
            else                           v = int'($urandom_range(0, 255)) - 128;
            idle($urandom_range(0, 2));
            send(v);
        end
        drain();
        rdy_rand = 1'b0;
        #1 i_ready = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
